// File: rtl/dec_pkg.sv
// Shared definitions for the one-hot decoder pipeline and its benches.
package dec_pkg;

  localparam int DEF_IN_W  = 2;
  localparam int DEF_CNT_W = 8;

  // Widest code the shared helper handles.
  localparam int ONEHOT_MAX_IN_W = 5;
  localparam int ONEHOT_MAX_W    = 2 ** ONEHOT_MAX_IN_W;

  // Occupancy of the main/skid register pair. The fourth encoding is illegal
  // and recovers to ST_EMPTY.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Reference one-hot of a code, zero-extended to the widest supported word.
  function automatic logic [ONEHOT_MAX_W-1:0] onehot_of(
    input logic [ONEHOT_MAX_IN_W-1:0] code
  );
    logic [ONEHOT_MAX_W-1:0] r;
    r = '0;
    r[code] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/onehot_decoder_pipe_if.sv
// Input and output handshake bundle of the one-hot decoder pipeline.
interface onehot_decoder_pipe_if #(
  parameter int IN_W  = 2,
  parameter int CNT_W = 8
);
  localparam int OUT_W = 2 ** IN_W;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_code;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_onehot;
  logic [IN_W-1:0]  out_code;
  logic [CNT_W-1:0] dec_count;

  // Producer/consumer side (drives codes in, accepts words out).
  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_onehot, out_code, dec_count
  );

  // Decoder side.
  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_onehot, out_code, dec_count
  );
endinterface

// File: rtl/bin2onehot.sv
// Purely combinational binary code to one-hot decoder.
module bin2onehot #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 2 ** IN_W
) (
  input  logic [IN_W-1:0]  code,
  output logic [OUT_W-1:0] onehot
);

  // Set the single bit whose index equals the code.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < OUT_W; i++) begin
      onehot[i] = (code == IN_W'(i));
    end
  end

endmodule

// File: rtl/onehot_decoder_pipe.sv
// Registered binary-to-one-hot decoder behind a 2-entry skid buffer, so that
// in_ready is a flop with no combinational path from out_ready. Also counts
// delivered words, saturating.
module onehot_decoder_pipe
  import dec_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic                 clk,
  input logic                 rst,
  onehot_decoder_pipe_if.slave bus
);

  localparam int OUT_W = 2 ** IN_W;

  state_e           state_q, state_d;
  logic             in_ready_q;
  logic [IN_W-1:0]  main_code_q, skid_code_q;
  logic [CNT_W-1:0] cnt_q;
  logic [OUT_W-1:0] main_onehot;

  logic accept, deliver, out_valid;
  logic load_main_in, load_main_skid, load_skid;

  assign out_valid = (state_q == ST_ONE) || (state_q == ST_FULL);
  assign accept    = bus.in_valid && in_ready_q;
  assign deliver   = out_valid && bus.out_ready;

  // Next occupancy and which register loads from where.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a value unassigned and a latch is never inferred.
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d      = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && deliver) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (deliver) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (deliver) begin
          state_d        = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Control state: occupancy, registered in_ready and the delivery counter.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments here, so every flop samples the values
    // from before this edge regardless of statement order.
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
      if (deliver && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Data registers: contents only matter while the occupancy says they are valid.
  always_ff @(posedge clk) begin
    // NOTE: no reset on the data path; outputs are gated by out_valid, so a
    // stale code after reset is never observable.
    if (load_main_in) begin
      main_code_q <= bus.in_code;
    end else if (load_main_skid) begin
      main_code_q <= skid_code_q;
    end
    if (load_skid) begin
      skid_code_q <= bus.in_code;
    end
  end

  bin2onehot #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_dec (
    .code   (main_code_q),
    .onehot (main_onehot)
  );

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid;
  assign bus.out_onehot = out_valid ? main_onehot : '0;
  assign bus.out_code   = out_valid ? main_code_q : '0;
  assign bus.dec_count  = cnt_q;

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Scoreboard bench for onehot_decoder_pipe: a CNT_W=8 instance under directed
// stimulus plus a CNT_W=3 twin fed the same inputs for the saturation case.
module tb_onehot_decoder_pipe;

  localparam int IN_W    = 2;
  localparam int CNT_A   = 8;
  localparam int CNT_B   = 3;
  localparam int MAX_A   = (1 << CNT_A) - 1;
  localparam int MAX_B   = (1 << CNT_B) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  onehot_decoder_pipe_if #(.IN_W(IN_W), .CNT_W(CNT_A)) bus_a ();
  onehot_decoder_pipe_if #(.IN_W(IN_W), .CNT_W(CNT_B)) bus_b ();

  assign bus_b.in_valid  = bus_a.in_valid;
  assign bus_b.in_code   = bus_a.in_code;
  assign bus_b.out_ready = bus_a.out_ready;

  onehot_decoder_pipe #(.IN_W(IN_W), .CNT_W(CNT_A)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  onehot_decoder_pipe #(.IN_W(IN_W), .CNT_W(CNT_B)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: codes accepted but not yet delivered, plus delivery totals.
  logic [IN_W-1:0] sb_q[$];
  int delivered_a = 0;
  int delivered_b = 0;

  always @(posedge rst) begin
    sb_q.delete();
    delivered_a = 0;
    delivered_b = 0;
  end

  // Mid-cycle monitor: inputs and outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("cnt_a", 32'(bus_a.dec_count), 32'((delivered_a > MAX_A) ? MAX_A : delivered_a));
      check("cnt_b", 32'(bus_b.dec_count), 32'((delivered_b > MAX_B) ? MAX_B : delivered_b));
      if (bus_a.out_valid) begin
        check("onehot_shape", 32'($onehot(bus_a.out_onehot)), 32'd1);
        if (sb_q.size() == 0) begin
          check("stale_word", 32'(bus_a.out_valid), 32'd0);
        end else begin
          check("out_code", 32'(bus_a.out_code), 32'(sb_q[0]));
          check("out_onehot", 32'(bus_a.out_onehot), 32'(4'b0001 << sb_q[0]));
        end
        if (bus_a.out_ready) begin
          if (sb_q.size() != 0) void'(sb_q.pop_front());
          delivered_a++;
        end
      end else begin
        check("idle_onehot", 32'(bus_a.out_onehot), 32'd0);
      end
      if (bus_b.out_valid && bus_b.out_ready) delivered_b++;
      if (bus_a.in_valid && bus_a.in_ready) sb_q.push_back(bus_a.in_code);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Stream n codes back-to-back with out_ready high, then drain the last one.
  task automatic stream(input int n, input string tag);
    bus_a.out_ready = 1'b1;
    bus_a.in_valid  = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus_a.in_code = IN_W'(i % 4);
      step();
      check({tag, "_valid"}, 32'(bus_a.out_valid), 32'd1);
      check({tag, "_code"}, 32'(bus_a.out_code), 32'(i % 4));
    end
    bus_a.in_valid = 1'b0;
    step();
  endtask

  initial begin
    bus_a.in_valid  = 1'b0;
    bus_a.in_code   = '0;
    bus_a.out_ready = 1'b0;

    // 1. Reset
    do_reset();
    check("rst_in_ready", 32'(bus_a.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst_onehot", 32'(bus_a.out_onehot), 32'd0);
    check("rst_count", 32'(bus_a.dec_count), 32'd0);

    // 2. Single word
    bus_a.out_ready = 1'b1;
    bus_a.in_valid  = 1'b1;
    bus_a.in_code   = 2'b10;
    step();
    bus_a.in_valid = 1'b0;
    check("single_valid", 32'(bus_a.out_valid), 32'd1);
    check("single_onehot", 32'(bus_a.out_onehot), 32'b0100);
    check("single_code", 32'(bus_a.out_code), 32'b10);
    step();
    check("single_drained", 32'(bus_a.out_valid), 32'd0);
    check("single_count", 32'(bus_a.dec_count), 32'd1);

    // 3. Backpressure
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.in_code   = 2'd0;
    step();
    check("bp_ready_1", 32'(bus_a.in_ready), 32'd1);
    bus_a.in_code = 2'd1;
    step();
    check("bp_ready_full", 32'(bus_a.in_ready), 32'd0);
    check("bp_hold_0", 32'(bus_a.out_onehot), 32'b0001);
    bus_a.in_code = 2'd3;
    repeat (3) begin
      step();
      check("bp_held_off", 32'(bus_a.in_ready), 32'd0);
      check("bp_hold", 32'(bus_a.out_onehot), 32'b0001);
    end
    bus_a.out_ready = 1'b1;
    step();
    check("bp_ready_back", 32'(bus_a.in_ready), 32'd1);
    check("bp_second", 32'(bus_a.out_onehot), 32'b0010);
    step();
    bus_a.in_valid = 1'b0;
    check("bp_third", 32'(bus_a.out_onehot), 32'b1000);
    step();
    check("bp_drained", 32'(bus_a.out_valid), 32'd0);
    check("bp_count", 32'(bus_a.dec_count), 32'd4);

    // 4. Streaming, counted from a fresh reset
    do_reset();
    stream(16, "stream");
    check("stream_count", 32'(bus_a.dec_count), 32'd16);
    check("stream_empty", 32'(bus_a.out_valid), 32'd0);

    // 5. Asynchronous reset while FULL
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.in_code   = 2'd2;
    step();
    bus_a.in_code = 2'd3;
    step();
    bus_a.in_valid = 1'b0;
    check("mid_full", 32'(bus_a.in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("mid_valid_drop", 32'(bus_a.out_valid), 32'd0);
    check("mid_in_ready", 32'(bus_a.in_ready), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    bus_a.out_ready = 1'b1;
    repeat (4) step();
    check("mid_no_stale", 32'(bus_a.out_valid), 32'd0);
    check("mid_count", 32'(bus_a.dec_count), 32'd0);

    // 6. Saturation on the 3-bit counter
    do_reset();
    stream(10, "sat");
    check("sat_count_b", 32'(bus_b.dec_count), 32'd7);
    check("sat_count_a", 32'(bus_a.dec_count), 32'd10);
    stream(2, "sat_more");
    check("sat_hold_b", 32'(bus_b.dec_count), 32'd7);
    check("sat_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
